// File: rtl/logic_reduce_pkg.sv
// rtl/logic_reduce_pkg.sv - op codes, state encoding and identity helper for logic_reduce_unit
package logic_reduce_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    // Callers narrow the result to their own width with a size cast.
    function automatic logic [MAX_WIDTH-1:0] op_identity(input op_e op);
        if (op == OP_AND || op == OP_XNOR) begin
            return '1;
        end
        return '0;
    endfunction

endpackage

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - combinational bitwise AND/OR/XOR/XNOR of two WIDTH-bit words
module logic_op_unit
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z
);

    always_comb begin
        case (op)
            OP_AND:  Z = X & Y;
            OP_OR:   Z = X | Y;
            OP_XOR:  Z = X ^ Y;
            default: Z = ~(X ^ Y);
        endcase
    end

endmodule

// File: rtl/logic_reduce_unit.sv
// rtl/logic_reduce_unit.sv - streaming bitwise reduction over a run of operands (option: LOGIC_REDUCE_INVERT_EN)
module logic_reduce_unit
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LEN_W-1:0] len,
`ifdef LOGIC_REDUCE_INVERT_EN
    input  logic             inv,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_e           state, state_n;
    op_e              op_q, op_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0] acc, acc_n, acc_op, id_val;
    logic             beat;

    assign id_val  = WIDTH'(op_identity(op_e'(op)));
    assign cnt_inc = cnt + LEN_W'(1);
    assign beat    = (state == S_ACCUM) && in_valid;

    logic_op_unit #(.WIDTH(WIDTH)) u_op (
        .op (op_q),
        .X  (acc),
        .Y  (A),
        .Z  (acc_op)
    );

    always_comb begin
        state_n = state;
        op_n    = op_q;
        len_n   = len_q;
        cnt_n   = cnt;
        acc_n   = acc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_n  = op_e'(op);
                    len_n = len;
                    cnt_n = '0;
                    acc_n = id_val;
                    // An empty run still produces one result: the identity.
                    state_n = (len == '0) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_n = acc_op;
                    cnt_n = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= OP_AND;
            len_q <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            len_q <= len_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);

`ifdef LOGIC_REDUCE_INVERT_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            inv_q <= inv;
        end
    end

    // Inversion applies only to the presented result, never to the accumulation.
    assign F = (inv_q && state == S_HOLD) ? ~acc : acc;
`else
    assign F = acc;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb/tb_logic_reduce_unit.sv - scoreboard bench for logic_reduce_unit
module tb_logic_reduce_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [3:0] len;
    logic       inv_bit;
    logic [7:0] A;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] F;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    logic_reduce_unit #(.WIDTH(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .len       (len),
`ifdef LOGIC_REDUCE_INVERT_EN
        .inv       (inv_bit),
`endif
        .A         (A),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_run(input logic [1:0] o, input logic [3:0] l, input logic iv);
        start   = 1'b1;
        op      = o;
        len     = l;
        inv_bit = iv;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({busy, in_ready, out_valid} !== 3'b000 || F !== 8'h00) begin
            $display("FAIL reset_state busy/in_ready/out_valid=%b F=%h required 000/00",
                     {busy, in_ready, out_valid}, F);
        end else n_pass++;
    endtask

    task automatic test_and_run();
        logic [7:0] b[3] = '{8'hFF, 8'hF0, 8'h3C};
        exp_q.push_back(8'hFF & 8'hF0 & 8'h3C);
        start_run(2'b00, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                $display("FAIL and_ready beat%0d in_ready=%b busy=%b required 1/1", i, in_ready, busy);
            end else n_pass++;
            in_valid = 1'b1;
            A        = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== exp_q[0]) begin
            $display("FAIL and_result out_valid=%b in_ready=%b F=%h required 1/0/%h",
                     out_valid, in_ready, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL and_done busy=%b out_valid=%b required 0/0", busy, out_valid);
        end else n_pass++;
    endtask

    task automatic test_xor_gaps();
        logic [7:0] b[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        int sent = 0;
        int accepted = 0;
        int cyc = 0;
        exp_q.push_back(8'h0F);
        start_run(2'b10, 4'd4, 1'b0);
        while (cyc < 40) begin
            if (out_valid) break;
            if (cyc % 2 == 0) begin
                in_valid = 1'b1;
                A        = (sent < 4) ? b[sent] : 8'hFF;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                accepted++;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (cyc >= 40) $display("FAIL xor_timeout cycles=%0d required out_valid before 40", cyc);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            A        = 8'hFF;
            if (in_ready) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_total++;
        if (accepted != 4) $display("FAIL xor_beats accepted=%0d required 4", accepted);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || F !== exp_q[0]) begin
            $display("FAIL xor_result out_valid=%b F=%h required 1/%h", out_valid, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        start_run(2'b01, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || F !== exp_q[0]) begin
            $display("FAIL or_len0 out_valid=%b busy=%b in_ready=%b F=%h required 1/1/0/%h",
                     out_valid, busy, in_ready, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL idle_gap out_valid=%b busy=%b required 0/0", out_valid, busy);
        end else n_pass++;
        // out_ready stays high: the consumer is ready before the result exists.
        start_run(2'b11, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || F !== exp_q[0]) begin
            $display("FAIL xnor_len0 out_valid=%b F=%h required 1/%h", out_valid, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL early_ready out_valid=%b busy=%b required 0/0", out_valid, busy);
        end else n_pass++;
    endtask

    task automatic test_hold_backpressure();
        logic [7:0] b[2] = '{8'h11, 8'h22};
        exp_q.push_back(8'h33);
        start_run(2'b01, 4'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            A        = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || F !== exp_q[0]) begin
                $display("FAIL hold_stable cycle%0d out_valid=%b F=%h required 1/%h",
                         i, out_valid, F, exp_q[0]);
            end else n_pass++;
            start = (i % 2 == 0);
            op    = 2'b00;
            len   = 4'd0;
            @(negedge clk);
        end
        start = 1'b0;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL hold_start_ignored busy=%b out_valid=%b required 0/0", busy, out_valid);
        end else n_pass++;
    endtask

    task automatic test_reset_midrun();
        start_run(2'b00, 4'd3, 1'b0);
        in_valid = 1'b1;
        A        = 8'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, in_ready, out_valid} !== 3'b000 || F !== 8'h00) begin
            $display("FAIL midrun_reset busy/in_ready/out_valid=%b F=%h required 000/00",
                     {busy, in_ready, out_valid}, F);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h5A);
        start_run(2'b00, 4'd1, 1'b0);
        in_valid = 1'b1;
        A        = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || F !== exp_q[0]) begin
            $display("FAIL after_reset out_valid=%b F=%h required 1/%h", out_valid, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef LOGIC_REDUCE_INVERT_EN
    task automatic test_invert();
        logic [7:0] b[2] = '{8'h0F, 8'h0C};
        exp_q.push_back(~(8'h0F & 8'h0C));
        start_run(2'b00, 4'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            A        = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || F !== exp_q[0]) begin
            $display("FAIL invert out_valid=%b F=%h required 1/%h", out_valid, F, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        inv_bit   = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        len       = 4'd0;
        inv_bit   = 1'b0;
        A         = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_and_run();
        test_xor_gaps();
        test_back_to_back();
        test_hold_backpressure();
        test_reset_midrun();
`ifdef LOGIC_REDUCE_INVERT_EN
        test_invert();
`endif
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/logic_reduce_unit.md
# logic_reduce_unit

Parametrised, sequential successor to the two-input gate cells. Streams a run of WIDTH-bit operands through a selectable bitwise operation (AND, OR, XOR, XNOR) and returns one reduced WIDTH-bit result per run over a valid/ready handshake. It sits between an operand source and a result consumer. It replaces chains of single gate instances when the operand count or width is not fixed.

## Interface
- WIDTH, default 8: operand and result width in bits.
- LEN_W, default 4: width of the run-length field; maximum run is 2^LEN_W-1 operands.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- op  input  2  operation, sampled with start: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- len  input  LEN_W  number of operands in the run, sampled with start.
- A  input  WIDTH  operand data.
- in_valid  input  1  A is valid.
- in_ready  output  1  unit accepts A this cycle.
- F  output  WIDTH  reduced result.
- out_valid  output  1  F is valid.
- out_ready  input  1  consumer accepts F.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE, start=1, len>0: latch op and len. Load the accumulator with the identity for op (AND/XNOR all ones, OR/XOR all zeros). Clear the beat counter. Go to ACCUM.
- IDLE, start=1, len=0: latch op. Load the identity. Go directly to HOLD, so F is the identity value.
- ACCUM: in_ready=1. A beat is accepted when in_valid=1 and in_ready=1. Each accepted beat does acc <= acc op A and increments the counter.
- ACCUM: when the accepted beat is number len, go to HOLD on the same edge, with the final acc.
- HOLD: out_valid=1, F=acc, in_ready=0. F and out_valid stay stable until out_ready=1. On out_valid=1 and out_ready=1, go to IDLE.
- start is ignored outside IDLE. In IDLE and HOLD, in_ready=0 and in_valid is ignored.
- XNOR reduction is applied pairwise, with the accumulator as the left operand.
- Counter width is LEN_W. No wrap is possible, because the counter stops at len.
- Reset at any time returns to IDLE and aborts any run in progress without producing a result.

## Timing
- Reset values: state=IDLE, acc=0, counter=0, F=0, out_valid=0, in_ready=0, busy=0.
- start accepted at edge k: in_ready=1 and busy=1 from cycle k+1 (len>0), or out_valid=1 from cycle k+1 (len=0).
- Latency: out_valid rises in the cycle after the edge that accepts the last beat.
- Back-to-back beats: one per cycle, with no bubbles.
- out_ready may be high before out_valid rises. The handshake completes in the first out_valid cycle, and IDLE follows on the next edge.
- After the handshake, the earliest new start is sampled in the IDLE cycle. That gives a minimum of one idle cycle between runs.
- in_ready, out_valid and busy are registered state decodes, with no combinational path from inputs.

## Configuration
- LOGIC_REDUCE_INVERT_EN defined: adds input port inv (1 bit), sampled with start. When inv=1, F is the bitwise complement of acc while in HOLD, giving NAND/NOR/XNOR-of-XOR variants. The identity value and accumulation are unchanged.
- LOGIC_REDUCE_INVERT_EN undefined: the inv port does not exist and F=acc.

## Structure
- Package logic_reduce_pkg holds:
  - op code constants: OP_AND, OP_OR, OP_XOR, OP_XNOR;
  - state encoding: S_IDLE, S_ACCUM, S_HOLD;
  - a function returning the WIDTH-bit identity for an op.
- One combinational sub-module, logic_op_unit (WIDTH, op, X, Y -> Z), computes acc op A. The top holds the FSM, counter and accumulator.

## Test plan
- WIDTH=8, op=AND, len=3, A=FF, F0, 3C with no gaps -> out_valid 1 cycle after 3rd beat, F=30, busy low after out_ready.
- op=XOR, len=4, A=01,02,04,08, in_valid toggled every other cycle -> F=0F, exactly 4 beats accepted.
- op=OR, len=0 -> out_valid next cycle, F=00. op=XNOR, len=0 -> F=FF.
- op=OR, len=2, A=11,22, out_ready held low 5 cycles -> F=33 stable and out_valid high throughout; start pulses during HOLD ignored.
- rst_n low mid-run after 1 of 3 beats -> all outputs 0 immediately; a new run after release (AND, len=1, A=5A) -> F=5A.
- With LOGIC_REDUCE_INVERT_EN: op=AND, inv=1, len=2, A=0F, 0C -> F=F3.
